// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: coin codes understood by the core and
// the coin emitter state encoding.
package vm_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StEmit = 2'd1,
    StGap  = 2'd2
  } emit_state_e;

endpackage

// File: rtl/coin_debounce.sv
// Two-flop synchroniser plus counter debouncer for one raw coin sensor.
// Emits the clean level and a one-cycle rise marker.
module coin_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);

  logic             sync1_q, sync2_q;
  logic             level_q, level_prev_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= raw_i;
      sync2_q      <= sync1_q;
      level_prev_q <= level_q;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        // This edge is the last of DEBOUNCE_CYCLES consecutive differing samples.
        level_q <= ~level_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign level_o = level_q;
  assign rise_o  = level_q & ~level_prev_q;

endmodule

// File: rtl/coin_input_conditioner.sv
// Turns raw bouncy coin sensors into single-cycle coin codes for the core,
// refusing coins while the core is busy or a coin of that type is still queued.
module coin_input_conditioner
  import vm_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 5,
  parameter int unsigned GAP_CYCLES      = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin5_raw,
  input  logic       coin10_raw,
  input  logic       inhibit,
  output logic [1:0] in_code,
  output logic       coin_reject,
  output logic [1:0] pending
);

  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  logic [1:0]      level, rise, ev;
  logic [1:0]      pending_q, pending_d;
  logic [1:0]      clr, rej, set;
  logic            reject_d;
  logic            gap_done, can_emit, take10, take5;
  logic [1:0]      in_code_q;
  logic            coin_reject_q;
  logic [GapW-1:0] gap_cnt_q;
  emit_state_e     state_q;

  coin_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_deb5 (
    .clk    (clk),
    .rst    (rst),
    .raw_i  (coin5_raw),
    .level_o(level[0]),
    .rise_o (rise[0])
  );

  coin_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_deb10 (
    .clk    (clk),
    .rst    (rst),
    .raw_i  (coin10_raw),
    .level_o(level[1]),
    .rise_o (rise[1])
  );

  always_comb begin
    ev       = rise & level;
    gap_done = (gap_cnt_q == GapW'(GAP_CYCLES - 1));
    // The last gap cycle doubles as an idle decision so codes can be 1+GAP apart.
    can_emit = (state_q == StIdle) || ((state_q == StGap) && gap_done);
    take10   = can_emit && !inhibit && pending_q[1];
    take5    = can_emit && !inhibit && !pending_q[1] && pending_q[0];
    clr      = {take10, take5};
    // A bit being emitted this edge is free again, so a new coin of that type is accepted.
    rej       = ev & ({2{inhibit}} | (pending_q & ~clr));
    set       = ev & ~rej;
    pending_d = (pending_q & ~clr) | set;
    reject_d  = |rej;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      in_code_q     <= COIN_NONE;
      pending_q     <= 2'b00;
      coin_reject_q <= 1'b0;
      gap_cnt_q     <= '0;
    end else begin
      pending_q     <= pending_d;
      coin_reject_q <= reject_d;
      case (state_q)
        StEmit: begin
          state_q   <= StGap;
          in_code_q <= COIN_NONE;
          gap_cnt_q <= '0;
        end
        StIdle, StGap: begin
          if ((state_q == StGap) && !gap_done) begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
            in_code_q <= COIN_NONE;
          end else if (take10) begin
            state_q   <= StEmit;
            in_code_q <= COIN_10;
          end else if (take5) begin
            state_q   <= StEmit;
            in_code_q <= COIN_5;
          end else begin
            state_q   <= StIdle;
            in_code_q <= COIN_NONE;
          end
        end
        default: begin
          state_q   <= StIdle;
          in_code_q <= COIN_NONE;
        end
      endcase
    end
  end

  assign in_code     = in_code_q;
  assign coin_reject = coin_reject_q;
  assign pending     = pending_q;

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Directed bench for coin_input_conditioner with DEBOUNCE_CYCLES=4, GAP_CYCLES=1.
module tb_coin_input_conditioner;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       coin5_raw = 1'b0;
  logic       coin10_raw = 1'b0;
  logic       inhibit = 1'b0;
  logic [1:0] in_code;
  logic       coin_reject;
  logic [1:0] pending;

  int checks = 0;
  int failures = 0;

  coin_input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3),
    .GAP_CYCLES     (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .coin5_raw  (coin5_raw),
    .coin10_raw (coin10_raw),
    .inhibit    (inhibit),
    .in_code    (in_code),
    .coin_reject(coin_reject),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  // Advance past one rising edge and settle before sampling.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    coin5_raw  = 1'b1;
    coin10_raw = 1'b1;
    rst        = 1'b1;
    for (int n = 0; n < 2; n++) begin
      cycle();
      checks++;
      if (in_code !== 2'b00) begin
        failures++;
        $display("FAIL reset_code n=%0d got=%b exp=00", n, in_code);
      end
      checks++;
      if (coin_reject !== 1'b0) begin
        failures++;
        $display("FAIL reset_reject n=%0d got=%b exp=0", n, coin_reject);
      end
      checks++;
      if (pending !== 2'b00) begin
        failures++;
        $display("FAIL reset_pending n=%0d got=%b exp=00", n, pending);
      end
    end
    coin5_raw  = 1'b0;
    coin10_raw = 1'b0;
    rst        = 1'b0;
  endtask

  task automatic test_single_coin();
    logic [1:0] exp_code, exp_pend;
    do_reset();
    coin5_raw = 1'b1;
    for (int n = 0; n < 22; n++) begin
      cycle();
      exp_code = (n == 7) ? 2'b01 : 2'b00;
      exp_pend = (n == 6) ? 2'b01 : 2'b00;
      checks++;
      if (in_code !== exp_code) begin
        failures++;
        $display("FAIL single_code n=%0d got=%b exp=%b", n, in_code, exp_code);
      end
      checks++;
      if (pending !== exp_pend) begin
        failures++;
        $display("FAIL single_pending n=%0d got=%b exp=%b", n, pending, exp_pend);
      end
      checks++;
      if (coin_reject !== 1'b0) begin
        failures++;
        $display("FAIL single_reject n=%0d got=%b exp=0", n, coin_reject);
      end
      if (n == 9) coin5_raw = 1'b0;
    end
  endtask

  task automatic test_glitch();
    logic [15:0] pattern;
    do_reset();
    // 3-cycle pulse, idle, then 1-0-1-0 bounce; LSB applied first.
    pattern = 16'b0000_0101_0000_0111;
    for (int n = 0; n < 24; n++) begin
      coin10_raw = (n < 16) ? pattern[n] : 1'b0;
      cycle();
      checks++;
      if (in_code !== 2'b00) begin
        failures++;
        $display("FAIL glitch_code n=%0d got=%b exp=00", n, in_code);
      end
      checks++;
      if (pending !== 2'b00) begin
        failures++;
        $display("FAIL glitch_pending n=%0d got=%b exp=00", n, pending);
      end
    end
    coin10_raw = 1'b0;
  endtask

  task automatic test_simultaneous();
    logic [1:0] exp_code, exp_pend;
    do_reset();
    coin5_raw  = 1'b1;
    coin10_raw = 1'b1;
    for (int n = 0; n < 22; n++) begin
      cycle();
      exp_code = (n == 7) ? 2'b10 : (n == 9) ? 2'b01 : 2'b00;
      exp_pend = (n == 6) ? 2'b11 : (n == 7 || n == 8) ? 2'b01 : 2'b00;
      checks++;
      if (in_code !== exp_code) begin
        failures++;
        $display("FAIL simul_code n=%0d got=%b exp=%b", n, in_code, exp_code);
      end
      checks++;
      if (pending !== exp_pend) begin
        failures++;
        $display("FAIL simul_pending n=%0d got=%b exp=%b", n, pending, exp_pend);
      end
      checks++;
      if (coin_reject !== 1'b0) begin
        failures++;
        $display("FAIL simul_reject n=%0d got=%b exp=0", n, coin_reject);
      end
      if (n == 7) begin
        coin5_raw  = 1'b0;
        coin10_raw = 1'b0;
      end
    end
  endtask

  task automatic test_inhibit_reject();
    logic exp_rej;
    do_reset();
    inhibit    = 1'b1;
    coin10_raw = 1'b1;
    for (int n = 0; n < 22; n++) begin
      cycle();
      exp_rej = (n == 6);
      checks++;
      if (coin_reject !== exp_rej) begin
        failures++;
        $display("FAIL inh_reject n=%0d got=%b exp=%b", n, coin_reject, exp_rej);
      end
      checks++;
      if (in_code !== 2'b00) begin
        failures++;
        $display("FAIL inh_code n=%0d got=%b exp=00", n, in_code);
      end
      checks++;
      if (pending !== 2'b00) begin
        failures++;
        $display("FAIL inh_pending n=%0d got=%b exp=00", n, pending);
      end
      if (n == 7) coin10_raw = 1'b0;
      if (n == 17) inhibit = 1'b0;
    end
  endtask

  task automatic test_inhibit_hold();
    logic [1:0] exp_code, exp_pend;
    do_reset();
    coin5_raw = 1'b1;
    for (int n = 0; n < 22; n++) begin
      cycle();
      exp_code = (n == 13) ? 2'b01 : 2'b00;
      exp_pend = (n >= 6 && n <= 12) ? 2'b01 : 2'b00;
      checks++;
      if (in_code !== exp_code) begin
        failures++;
        $display("FAIL hold_code n=%0d got=%b exp=%b", n, in_code, exp_code);
      end
      checks++;
      if (pending !== exp_pend) begin
        failures++;
        $display("FAIL hold_pending n=%0d got=%b exp=%b", n, pending, exp_pend);
      end
      if (n == 6) inhibit = 1'b1;
      if (n == 9) coin5_raw = 1'b0;
      if (n == 12) inhibit = 1'b0;
    end
  endtask

  task automatic test_reset_midstream();
    logic [1:0] exp_pend;
    do_reset();
    coin5_raw = 1'b1;
    for (int n = 0; n < 26; n++) begin
      cycle();
      exp_pend = (n == 6) ? 2'b01 : 2'b00;
      checks++;
      if (pending !== exp_pend) begin
        failures++;
        $display("FAIL midrst_pending n=%0d got=%b exp=%b", n, pending, exp_pend);
      end
      checks++;
      if (in_code !== 2'b00) begin
        failures++;
        $display("FAIL midrst_code n=%0d got=%b exp=00", n, in_code);
      end
      if (n == 5) coin5_raw = 1'b0;
      rst = (n == 6);
    end
    rst = 1'b0;
  endtask

  task automatic test_stuck_through_reset();
    logic [1:0] exp_code;
    coin5_raw = 1'b1;
    do_reset();
    for (int n = 0; n < 24; n++) begin
      cycle();
      exp_code = (n == 7) ? 2'b01 : 2'b00;
      checks++;
      if (in_code !== exp_code) begin
        failures++;
        $display("FAIL stuck_code n=%0d got=%b exp=%b", n, in_code, exp_code);
      end
      if (n == 14) coin5_raw = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_single_coin();
    test_glitch();
    test_simultaneous();
    test_inhibit_reject();
    test_inhibit_hold();
    test_reset_midstream();
    test_stuck_through_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
